// File: rtl/truth_table_pkg.sv
// Shared types and constants for the exhaustive 4-input truth-table sequencer.
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NUM_VECTORS = 16;
    localparam int unsigned VEC_W       = 4;
    localparam int unsigned HOLD_W      = 4;

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle timer: counts cycles a vector has been driven and ticks on the last one.
module settle_timer
    import truth_table_pkg::*;
#(
    parameter int unsigned HOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;

    assign tick = en && (hold_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hold_cnt <= '0;
        end else if (en) begin
            if (hold_cnt == LAST) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks all 16 input vectors of a 4-input function, compares f against EXPECTED
// and reports pass/fail, mismatch count and the lowest failing vector.
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter logic [15:0] EXPECTED = 16'h0000,
    parameter int unsigned HOLD     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       fail_valid,
    output logic [3:0] first_fail
);

    state_t            state, next_state;
    logic [VEC_W-1:0]  idx;
    logic              tick;
    logic              accept;
    logic              sample;
    logic              last;
    logic              mismatch;

    settle_timer #(
        .HOLD (HOLD)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (busy),
        .tick  (tick)
    );

    // idx returns to 0 whenever not running, so it drives the DUT directly
    assign {a, b, c, d} = idx;
    assign busy         = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        sample     = 1'b0;
        last       = 1'b0;
        mismatch   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    sample   = 1'b1;
                    mismatch = (f != EXPECTED[idx]);
                    last     = (idx == VEC_W'(NUM_VECTORS - 1));
                    if (last) begin
                        next_state = DONE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            idx        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (sample) begin
            idx <= idx + 1'b1;
            if (mismatch) begin
                err_count <= err_count + 1'b1;
                if (!fail_valid) begin
                    first_fail <= idx;
                    fail_valid <= 1'b1;
                end
            end
            if (last) begin
                done <= 1'b1;
                pass <= ((err_count + {4'b0, mismatch}) == '0);
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: three instances (HOLD 2/1/3) checked every cycle
// against a timeline model plus hand-computed result literals.
module tb_truth_table_sequencer;

    localparam logic [15:0] EXP_P = 16'hB2C4;

    logic       clk = 1'b0;
    logic       rst_s   [3];
    logic       start_s [3];
    logic       f_s     [3];
    logic [3:0] va      [3];
    logic       busy_a  [3];
    logic       done_a  [3];
    logic       pass_a  [3];
    logic [4:0] err_a   [3];
    logic       fv_a    [3];
    logic [3:0] ff_a    [3];

    int         mode  [3];
    logic [15:0] exp_tt = EXP_P;

    int  nvec = 0;
    int  nerr = 0;
    bit  chk_en = 0;
    int  vlog[$];

    always #5 clk = ~clk;

    truth_table_sequencer #(.EXPECTED(EXP_P), .HOLD(2)) u0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .f(f_s[0]),
        .a(va[0][3]), .b(va[0][2]), .c(va[0][1]), .d(va[0][0]),
        .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .err_count(err_a[0]),
        .fail_valid(fv_a[0]), .first_fail(ff_a[0]));

    truth_table_sequencer #(.EXPECTED(EXP_P), .HOLD(1)) u1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .f(f_s[1]),
        .a(va[1][3]), .b(va[1][2]), .c(va[1][1]), .d(va[1][0]),
        .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .err_count(err_a[1]),
        .fail_valid(fv_a[1]), .first_fail(ff_a[1]));

    truth_table_sequencer #(.EXPECTED(EXP_P), .HOLD(3)) u2 (
        .clk(clk), .rst(rst_s[2]), .start(start_s[2]), .f(f_s[2]),
        .a(va[2][3]), .b(va[2][2]), .c(va[2][1]), .d(va[2][0]),
        .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]), .err_count(err_a[2]),
        .fail_valid(fv_a[2]), .first_fail(ff_a[2]));

    // Emulated DUT: 0 = correct, 1 = stuck-at-0, 2 = wrong only at vector 15
    function automatic bit dut_f(int m, int v);
        logic [15:0] tt;
        tt = exp_tt;
        case (m)
            1:       return 1'b0;
            2:       return (v == 15) ? ~tt[v] : tt[v];
            default: return tt[v];
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) f_s[i] = dut_f(mode[i], int'(va[i]));
    end

    function automatic int hold_of(int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 3;
    endfunction

    // Model: cycles elapsed since the accepted start; everything else follows from it
    int t    [3] = '{0, 0, 0};
    bit run  [3] = '{0, 0, 0};
    bit fin  [3] = '{0, 0, 0};
    int mm   [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_s[i]) begin
                run[i] <= 0; fin[i] <= 0; t[i] <= 0;
            end else if (start_s[i] && !run[i]) begin
                run[i] <= 1; fin[i] <= 0; t[i] <= 0; mm[i] <= mode[i];
            end else if (run[i]) begin
                if (t[i] + 1 == 16 * hold_of(i)) begin
                    run[i] <= 0; fin[i] <= 1;
                end
                t[i] <= t[i] + 1;
            end
        end
    end

    function automatic int sampled(int i);
        return run[i] ? t[i] / hold_of(i) : (fin[i] ? 16 : 0);
    endfunction

    function automatic int m_err(int i);
        int n = 0;
        for (int j = 0; j < sampled(i); j++) if (dut_f(mm[i], j) != exp_tt[j]) n++;
        return n;
    endfunction

    function automatic int m_first(int i);
        for (int j = 0; j < sampled(i); j++) if (dut_f(mm[i], j) != exp_tt[j]) return j;
        return 0;
    endfunction

    task automatic chk(string nm, int u, int act, int expv);
        nvec++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s u%0d: got %0d, expected %0d (t=%0t)", nm, u, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk("busy", i, int'(busy_a[i]), int'(run[i]));
                chk("vec", i, int'(va[i]), run[i] ? t[i] / hold_of(i) : 0);
                chk("done", i, int'(done_a[i]), int'(fin[i]));
                chk("err_count", i, int'(err_a[i]), m_err(i));
                chk("fail_valid", i, int'(fv_a[i]), int'(m_err(i) > 0));
                chk("first_fail", i, int'(ff_a[i]), m_first(i));
                chk("pass", i, int'(pass_a[i]), int'(fin[i] && m_err(i) == 0));
            end
        end
    end

    // Pulse start, then follow the sweep until busy drops; ends at the first non-busy cycle
    task automatic sweep(int u, int m, output int cyc);
        mode[u] = m;
        start_s[u] = 1'b1;
        @(negedge clk);
        start_s[u] = 1'b0;
        cyc = 0;
        vlog.delete();
        for (int j = 0; j < 100; j++) begin
            if (!busy_a[u]) break;
            vlog.push_back(int'(va[u]));
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int k;
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1; start_s[i] = 1'b0; mode[i] = 0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
        chk_en = 1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_outputs", i,
                int'({busy_a[i], done_a[i], pass_a[i], fv_a[i], err_a[i], ff_a[i], va[i]}), 0);
        end

        // Matching DUT, HOLD=2
        sweep(0, 0, cyc);
        chk("lat_match", 0, cyc, 32);
        chk("done_match", 0, int'(done_a[0]), 1);
        chk("pass_match", 0, int'(pass_a[0]), 1);
        chk("err_match", 0, int'(err_a[0]), 0);
        chk("fv_match", 0, int'(fv_a[0]), 0);

        // Stuck-at-0 DUT, restarted from DONE
        sweep(0, 1, cyc);
        chk("lat_sa0", 0, cyc, 32);
        chk("err_sa0", 0, int'(err_a[0]), 7);
        chk("first_sa0", 0, int'(ff_a[0]), 2);
        chk("fv_sa0", 0, int'(fv_a[0]), 1);
        chk("pass_sa0", 0, int'(pass_a[0]), 0);

        // Reset mid-sweep at idx 9
        mode[0] = 1;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        k = 0;
        while (va[0] != 4'd9 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("reach_idx9", 0, int'(va[0]), 9);
        chk("err_at_idx9", 0, int'(err_a[0]), 3);
        rst_s[0] = 1'b1;
        @(negedge clk);
        rst_s[0] = 1'b0;
        chk("rst_mid", 0,
            int'({busy_a[0], done_a[0], pass_a[0], fv_a[0], err_a[0], ff_a[0], va[0]}), 0);
        sweep(0, 0, cyc);
        chk("lat_after_rst", 0, cyc, 32);
        chk("pass_after_rst", 0, int'(pass_a[0]), 1);

        // start held high: DONE lasts one cycle, then a new sweep begins
        mode[0] = 0;
        start_s[0] = 1'b1;
        @(negedge clk);
        k = 0;
        while (!done_a[0] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("held_done_cycle", 0, k, 32);
        chk("held_done", 0, int'(done_a[0]), 1);
        @(negedge clk);
        chk("held_done_drop", 0, int'(done_a[0]), 0);
        chk("held_busy_again", 0, int'(busy_a[0]), 1);
        chk("held_vec0", 0, int'(va[0]), 0);
        start_s[0] = 1'b0;
        k = 0;
        while (!done_a[0] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("held_second_done", 0, int'(done_a[0]), 1);

        // Vector order with HOLD=1
        sweep(1, 0, cyc);
        chk("order_len", 1, vlog.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("order_vec", 1, (i < vlog.size()) ? vlog[i] : -1, i);
        end
        chk("order_vec_after", 1, int'(va[1]), 0);
        chk("order_done", 1, int'(done_a[1]), 1);

        // Last-vector fail with HOLD=3
        sweep(2, 2, cyc);
        chk("lat_last", 2, cyc, 48);
        chk("err_last", 2, int'(err_a[2]), 1);
        chk("first_last", 2, int'(ff_a[2]), 15);
        chk("pass_last", 2, int'(pass_a[2]), 0);
        chk("done_last", 2, int'(done_a[2]), 1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
